// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: receiver state encoding and 8N1 frame constants.
package loader_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rxd synchroniser, mid-bit sampling FSM, start-glitch rejection, framing check.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | half a bit into the start bit, re-check it is still low
// DATA  | sampling 8 data bits LSB first at mid-bit
// STOP  | sampling the stop bit; high = good byte, low = framing error
// BREAK | line held low after a framing error, wait for it to return high
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int             TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

    logic            rxd_meta_q;
    logic            rxd_s_q;
    rx_state_e       state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            tcnt_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    // Bit timer is a down-counter; every sample point is its terminal count.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        tcnt_done  = (tcnt_q == '0);

        case (state_q)
            IDLE: begin
                if (!rxd_s_q) begin
                    state_d = START;
                    tcnt_d  = HALF_LOAD;
                end
            end
            START: begin
                if (!tcnt_done) begin
                    tcnt_d = tcnt_q - 1'b1;
                end else if (rxd_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    bit_d   = '0;
                    tcnt_d  = FULL_LOAD;
                end
            end
            DATA: begin
                if (!tcnt_done) begin
                    tcnt_d = tcnt_q - 1'b1;
                end else begin
                    data_d = {rxd_s_q, data_q[7:1]};
                    tcnt_d = FULL_LOAD;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (!tcnt_done) begin
                    tcnt_d = tcnt_q - 1'b1;
                end else if (rxd_s_q) begin
                    byte_valid = 1'b1;
                    state_d    = IDLE;
                end else begin
                    frame_err = 1'b1;
                    state_d   = BREAK;
                end
            end
            BREAK: begin
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_out = data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: assembles received bytes little-endian into words and writes them
// sequentially into instruction memory until DEPTH words are loaded.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 50,
    parameter int WORD_BYTES    = 4,
    parameter int DEPTH         = 512,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int RESYNC_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rxd,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    init_done,
    output logic                    busy,
    output logic [7:0]              frame_err_cnt
);

    localparam int                WW        = 8 * WORD_BYTES;
    localparam int                IDX_W     = $clog2(WORD_BYTES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_BYTES - 1);
    localparam int                RS_W      = (RESYNC_CYCLES > 0) ? $clog2(RESYNC_CYCLES + 1) : 1;
    localparam logic [RS_W-1:0]   RS_LOAD   = RS_W'(RESYNC_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ferr;
    logic              rx_busy;

    logic [WW-1:0]     shift_q, shift_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              init_done_q, init_done_d;
    logic [7:0]        ferr_cnt_q, ferr_cnt_d;
    logic [RS_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WW+7:0]     shift_ext;
    logic [WW-1:0]     appended;
    logic              accept;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .byte_out   (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr),
        .busy       (rx_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            byte_idx_q  <= '0;
            word_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            init_done_q <= 1'b0;
            ferr_cnt_q  <= '0;
            idle_cnt_q  <= RS_LOAD;
        end else begin
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            word_cnt_q  <= word_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            init_done_q <= init_done_d;
            ferr_cnt_q  <= ferr_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    // New byte enters at the top so the first byte of a word ends up in bits [7:0].
    assign shift_ext = {rx_byte, shift_q};
    assign appended  = shift_ext[WW+7:8];
    assign accept    = rx_valid && !init_done_q && !word_cnt_q[ADDR_W];

    always_comb begin
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        word_cnt_d  = word_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        idle_cnt_d  = idle_cnt_q;
        ferr_cnt_d  = ferr_cnt_q;
        init_done_d = init_done_q || (mem_we_q && (mem_addr_q == LAST_ADDR));

        if (rx_ferr && (ferr_cnt_q != 8'hFF)) begin
            ferr_cnt_d = ferr_cnt_q + 8'd1;
        end

        if (rx_valid) begin
            idle_cnt_d = RS_LOAD;
            if (accept) begin
                if (byte_idx_q == LAST_IDX) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = appended;
                    mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                    word_cnt_d  = word_cnt_q + 1'b1;
                    byte_idx_d  = '0;
                    shift_d     = '0;
                end else begin
                    shift_d    = appended;
                    byte_idx_d = byte_idx_q + 1'b1;
                end
            end
        end else if ((RESYNC_CYCLES > 0) && (byte_idx_q != '0) && !rx_busy) begin
            // Partial word has sat idle too long: drop it so the next byte starts a fresh word.
            if (idle_cnt_q == '0) begin
                byte_idx_d = '0;
                shift_d    = '0;
                idle_cnt_d = RS_LOAD;
            end else begin
                idle_cnt_d = idle_cnt_q - 1'b1;
            end
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign init_done     = init_done_q;
    assign busy          = rx_busy;
    assign frame_err_cnt = ferr_cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader (4-byte words, 8-word memory, resync enabled).
module tb_uart_prog_loader;

    localparam int CPB     = 50;
    localparam int WB      = 4;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int RESYNC  = 2000;
    localparam int LAT     = 9 * CPB + CPB / 2 + 3;

    logic          clk;
    logic          rst;
    logic          rxd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          init_done;
    logic          busy;
    logic [7:0]    frame_err_cnt;

    int            cyc;
    int            n_checks;
    int            n_pass;
    int            last_start;
    bit            busy_seen;
    bit            done_seen;
    int            done_cyc;
    int            q_addr[$];
    logic [31:0]   q_data[$];
    int            q_cyc[$];

    uart_prog_loader #(
        .CLKS_PER_BIT  (CPB),
        .WORD_BYTES    (WB),
        .DEPTH         (DEPTH),
        .ADDR_W        (AW),
        .RESYNC_CYCLES (RESYNC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .init_done     (init_done),
        .busy          (busy),
        .frame_err_cnt (frame_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            q_addr.push_back(int'(mem_addr));
            q_data.push_back(mem_wdata);
            q_cyc.push_back(cyc);
        end
        if (busy) busy_seen = 1'b1;
        if (init_done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation still running after 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_writes();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic pop_write(output int a, output logic [31:0] d, output int c);
        if (q_addr.size() > 0) begin
            a = q_addr.pop_front();
            d = q_data.pop_front();
            c = q_cyc.pop_front();
        end else begin
            a = -1;
            d = 'x;
            c = -1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        last_start = cyc;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_frame(w[8*i +: 8], 1'b1);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        n_checks += 6;
        if (mem_we !== 1'b0) $display("FAIL %s mem_we: got %b want 0", tag, mem_we); else n_pass++;
        if (mem_addr !== '0) $display("FAIL %s mem_addr: got %0d want 0", tag, mem_addr); else n_pass++;
        if (mem_wdata !== 32'h0) $display("FAIL %s mem_wdata: got %h want 0", tag, mem_wdata); else n_pass++;
        if (init_done !== 1'b0) $display("FAIL %s init_done: got %b want 0", tag, init_done); else n_pass++;
        if (busy !== 1'b0) $display("FAIL %s busy: got %b want 0", tag, busy); else n_pass++;
        if (frame_err_cnt !== 8'd0) $display("FAIL %s frame_err_cnt: got %0d want 0", tag, frame_err_cnt); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_normal_word();
        int a, c;
        logic [31:0] d;
        clear_writes();
        send_frame(8'h78, 1'b1);
        send_frame(8'h56, 1'b1);
        send_frame(8'h34, 1'b1);
        send_frame(8'h12, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++;
        if (q_addr.size() !== 1) $display("FAIL normal_count: got %0d writes want 1", q_addr.size()); else n_pass++;
        pop_write(a, d, c);
        n_checks += 4;
        if (a !== 0) $display("FAIL normal_addr: got %0d want 0", a); else n_pass++;
        if (d !== 32'h12345678) $display("FAIL normal_data: got %h want 12345678", d); else n_pass++;
        if (c - last_start !== LAT) $display("FAIL normal_latency: got %0d want %0d cycles", c - last_start, LAT); else n_pass++;
        if (frame_err_cnt !== 8'd0) $display("FAIL normal_ferr: got %0d want 0", frame_err_cnt); else n_pass++;
    endtask

    task automatic test_glitch();
        clear_writes();
        @(negedge clk);
        busy_seen = 1'b0;
        rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_checks += 4;
        if (busy_seen !== 1'b1) $display("FAIL glitch_start: busy never rose, want 1"); else n_pass++;
        if (busy !== 1'b0) $display("FAIL glitch_idle: busy got %b want 0", busy); else n_pass++;
        if (q_addr.size() !== 0) $display("FAIL glitch_write: got %0d writes want 0", q_addr.size()); else n_pass++;
        if (frame_err_cnt !== 8'd0) $display("FAIL glitch_ferr: got %0d want 0", frame_err_cnt); else n_pass++;
    endtask

    task automatic test_framing();
        int a, c;
        logic [31:0] d;
        clear_writes();
        send_frame(8'hAA, 1'b0);
        rxd = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL frame_break_busy: got %b want 1", busy); else n_pass++;
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_checks += 3;
        if (frame_err_cnt !== 8'd1) $display("FAIL frame_cnt: got %0d want 1", frame_err_cnt); else n_pass++;
        if (q_addr.size() !== 0) $display("FAIL frame_write: got %0d writes want 0", q_addr.size()); else n_pass++;
        if (busy !== 1'b0) $display("FAIL frame_release: busy got %b want 0", busy); else n_pass++;
        send_word(32'hEFBEADDE);
        pop_write(a, d, c);
        n_checks += 3;
        if (a !== 1) $display("FAIL frame_next_addr: got %0d want 1", a); else n_pass++;
        if (d !== 32'hEFBEADDE) $display("FAIL frame_next_data: got %h want efbeadde", d); else n_pass++;
        if (frame_err_cnt !== 8'd1) $display("FAIL frame_cnt_after: got %0d want 1", frame_err_cnt); else n_pass++;
    endtask

    task automatic test_resync();
        int a, c;
        logic [31:0] d;
        clear_writes();
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        repeat (RESYNC + 100) @(negedge clk);
        n_checks++;
        if (q_addr.size() !== 0) $display("FAIL resync_partial: got %0d writes want 0", q_addr.size()); else n_pass++;
        send_word(32'h04030201);
        n_checks++;
        if (q_addr.size() !== 1) $display("FAIL resync_count: got %0d writes want 1", q_addr.size()); else n_pass++;
        pop_write(a, d, c);
        n_checks += 2;
        if (a !== 2) $display("FAIL resync_addr: got %0d want 2", a); else n_pass++;
        if (d !== 32'h04030201) $display("FAIL resync_data: got %h want 04030201", d); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int a, c;
        logic [31:0] d;
        clear_writes();
        send_word(32'hA3A3A3A3);
        send_word(32'hA4A4A4A4);
        n_checks++;
        if (q_addr.size() !== 2) $display("FAIL midrst_prefill: got %0d writes want 2", q_addr.size()); else n_pass++;
        clear_writes();
        send_frame(8'h55, 1'b1);
        send_frame(8'h66, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midrst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (q_addr.size() !== 0) $display("FAIL midrst_nowrite: got %0d writes want 0", q_addr.size()); else n_pass++;
        send_word(32'h11223344);
        pop_write(a, d, c);
        n_checks += 2;
        if (a !== 0) $display("FAIL midrst_addr: got %0d want 0", a); else n_pass++;
        if (d !== 32'h11223344) $display("FAIL midrst_data: got %h want 11223344", d); else n_pass++;
    endtask

    task automatic test_full_load();
        int a, c;
        logic [31:0] d;
        logic [31:0] exp;
        logic [7:0] b;
        clear_writes();
        done_seen = 1'b0;
        for (int w = 1; w < DEPTH; w++) begin
            b   = 8'(w);
            exp = {b + 8'h30, b + 8'h20, b + 8'h10, b};
            if (w == DEPTH - 1) begin
                n_checks++;
                if (init_done !== 1'b0) $display("FAIL full_early_done: got %b want 0", init_done); else n_pass++;
            end
            send_word(exp);
            pop_write(a, d, c);
            n_checks += 2;
            if (a !== w) $display("FAIL full_addr%0d: got %0d want %0d", w, a, w); else n_pass++;
            if (d !== exp) $display("FAIL full_data%0d: got %h want %h", w, d, exp); else n_pass++;
        end
        n_checks += 2;
        if (init_done !== 1'b1) $display("FAIL full_done: got %b want 1", init_done); else n_pass++;
        if (done_cyc !== c + 1) $display("FAIL full_done_timing: rose at %0d want %0d", done_cyc, c + 1); else n_pass++;
        clear_writes();
        send_word(32'hCAFEF00D);
        n_checks += 3;
        if (q_addr.size() !== 0) $display("FAIL post_done_write: got %0d writes want 0", q_addr.size()); else n_pass++;
        if (init_done !== 1'b1) $display("FAIL post_done_sticky: got %b want 1", init_done); else n_pass++;
        if (frame_err_cnt !== 8'd0) $display("FAIL post_done_ferr: got %0d want 0", frame_err_cnt); else n_pass++;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        last_start = 0;
        busy_seen  = 1'b0;
        done_seen  = 1'b0;
        done_cyc   = -1;
        rst        = 1'b1;
        rxd        = 1'b1;
        test_reset();
        test_normal_word();
        test_glitch();
        test_framing();
        test_resync();
        test_reset_mid_load();
        test_full_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
